traffic_rr_ctrl: RTL

Parametrised multi-approach traffic signal controller: the successor to the fixed three-road-plus-turn controller, generalised to NUM_PHASES vehicle approaches plus one pedestrian crossing phase. Latches car sensor and pedestrian button requests, serves pending slots in round-robin order, and sequences each vehicle phase through green, yellow and all-red with parameter-set dwell times. Sits between the sensor inputs and the lamp drivers, and replaces the separate yellow, stop and five counters plus the pedestrian register.

---
 rtl/traffic_rr_ctrl_pkg.sv | 24 ++
 rtl/traffic_rr_ctrl_if.sv | 50 +++++
 rtl/traffic_rr_ctrl_dwell_timer.sv | 39 +++
 rtl/traffic_rr_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_rr_ctrl_pkg.sv
// traffic_rr_ctrl_pkg: shared types for the round-robin traffic controller.
// Holds the controller state enum, the slot index type and the helper that
// locates the pedestrian slot after the vehicle approaches.
package traffic_rr_ctrl_pkg;

   // Wide enough for up to 8 vehicle approaches plus the pedestrian slot.
   localparam int SLOT_W = 4;

   typedef logic [SLOT_W-1:0] slot_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GREEN  = 3'd1,
      S_YELLOW = 3'd2,
      S_ALLRED = 3'd3,
      S_WALK   = 3'd4
   } state_t;

   // The pedestrian crossing always sits directly after the last approach.
   function automatic int ped_slot(input int num_phases);
      return num_phases;
   endfunction

endpackage

// File: rtl/traffic_rr_ctrl_if.sv
// traffic_rr_ctrl_if: sensor-side requests and lamp-side outputs of the
// traffic controller, bundled so the controller and its environment share a
// single port.
//
// Request semantics: car_req and ped_btn are plain level inputs sampled on
// every rising clock edge; there is no valid/ready pairing and no
// backpressure. A 1 on any sampled edge latches a pending request inside the
// controller, so a single-cycle pulse is enough. The lamp outputs and
// phase_idx are valid in every cycle.
interface traffic_rr_ctrl_if #(
   parameter int NUM_PHASES = 4
);
   import traffic_rr_ctrl_pkg::*;

   localparam int IDX_W = $clog2(ped_slot(NUM_PHASES) + 1);

   logic [NUM_PHASES-1:0] car_req;
   logic                  ped_btn;
   logic [NUM_PHASES-1:0] red;
   logic [NUM_PHASES-1:0] yellow;
   logic [NUM_PHASES-1:0] green;
   logic                  walk;
   logic                  dont_walk;
   logic [IDX_W-1:0]      phase_idx;

   // Environment side: drives the sensors, watches the lamps.
   modport master (
      output car_req,
      output ped_btn,
      input  red,
      input  yellow,
      input  green,
      input  walk,
      input  dont_walk,
      input  phase_idx
   );

   // Controller side: reads the sensors, drives the lamps.
   modport slave (
      input  car_req,
      input  ped_btn,
      output red,
      output yellow,
      output green,
      output walk,
      output dont_walk,
      output phase_idx
   );

endinterface

// File: rtl/traffic_rr_ctrl_dwell_timer.sv
// dwell_timer: loadable down counter used for every timed phase dwell.
// A load wins over a decrement; the count parks at zero instead of wrapping,
// and zero_o tells the controller the dwell has run out.
module dwell_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: load has priority, decrement only while above zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/traffic_rr_ctrl.sv
// traffic_rr_ctrl: NUM_PHASES-approach traffic signal controller with one
// pedestrian crossing slot. Requests are latched into pending bits and the
// pending slots are served round-robin, starting after the slot served last.
// Vehicle slots run GREEN -> YELLOW -> ALLRED, the pedestrian slot runs
// WALK -> ALLRED, and every service returns through IDLE.
//
// Build option: define TRAFFIC_GAP_EXTEND_EN to hold a green past GREEN_TICKS
// while its approach still reports a car, up to MAX_GREEN_TICKS in total. In
// that build a car seen during its own green does not re-latch a request.
module traffic_rr_ctrl
   import traffic_rr_ctrl_pkg::*;
#(
   parameter int NUM_PHASES      = 4,
   parameter int CNT_W           = 4,
   parameter int GREEN_TICKS     = 4,
   parameter int YELLOW_TICKS    = 2,
   parameter int WALK_TICKS      = 3,
   parameter int MAX_GREEN_TICKS = 8
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   traffic_rr_ctrl_if.slave        bus,
   output state_t                  state_o
);

   localparam int NSLOT = NUM_PHASES + 1;
   localparam int PED   = ped_slot(NUM_PHASES);
   localparam int IDX_W = $clog2(PED + 1);

`ifdef TRAFFIC_GAP_EXTEND_EN
   localparam bit GAP_EXT_EN = 1'b1;
`else
   localparam bit GAP_EXT_EN = 1'b0;
`endif

   // Extension only makes sense when the ceiling leaves room above the base.
   localparam bit CAN_EXTEND = GAP_EXT_EN && (MAX_GREEN_TICKS > GREEN_TICKS);
   localparam int EXT_N      = (MAX_GREEN_TICKS > GREEN_TICKS) ?
                               (MAX_GREEN_TICKS - GREEN_TICKS - 1) : 0;

   localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);
   localparam logic [CNT_W-1:0] EXT_LD    = CNT_W'(EXT_N);

   state_t             state_q, state_d;
   slot_t              last_q, last_d;
   logic [NUM_PHASES:0] pend_q, pend_d;
   logic               ext_q, ext_d;

   logic               tmr_load;
   logic               tmr_en;
   logic [CNT_W-1:0]   tmr_val;
   logic               tmr_zero;

   logic               found_hi, found_lo;
   slot_t              hi_slot, lo_slot;
   logic [NUM_PHASES:0] hi_oh, lo_oh;
   logic               grant_found;
   slot_t              grant_slot;
   logic [NUM_PHASES:0] grant_oh;

   logic [NUM_PHASES-1:0] serve_oh;
   logic               cur_car;
   logic [NUM_PHASES:0] req_vec;

   assign req_vec = {bus.ped_btn, bus.car_req};

   // One-hot of the approach currently (or last) served; zero for the crossing.
   always_comb begin
      serve_oh = '0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         serve_oh[i] = (last_q == slot_t'(i));
      end
   end

   assign cur_car = |(bus.car_req & serve_oh);

   // Round-robin pick: lowest pending slot above last, else lowest at or below it.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      hi_slot  = '0;
      lo_slot  = '0;
      hi_oh    = '0;
      lo_oh    = '0;
      for (int s = 0; s < NSLOT; s++) begin
         if (pend_q[s] && !found_hi && (slot_t'(s) > last_q)) begin
            found_hi = 1'b1;
            hi_slot  = slot_t'(s);
            hi_oh[s] = 1'b1;
         end
         if (pend_q[s] && !found_lo && (slot_t'(s) <= last_q)) begin
            found_lo = 1'b1;
            lo_slot  = slot_t'(s);
            lo_oh[s] = 1'b1;
         end
      end
      grant_found = found_hi | found_lo;
      grant_slot  = found_hi ? hi_slot : lo_slot;
      grant_oh    = found_hi ? hi_oh : lo_oh;
   end

   // Next state, pending latches, served slot and dwell timer control.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      ext_d    = ext_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = '0;

      // With extension, the approach in green cannot queue itself again.
      if (GAP_EXT_EN && (state_q == S_GREEN)) begin
         pend_d = pend_q | (req_vec & ~{1'b0, serve_oh});
      end else begin
         pend_d = pend_q | req_vec;
      end

      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               last_d   = grant_slot;
               pend_d   = pend_d & ~grant_oh;
               ext_d    = 1'b0;
               tmr_load = 1'b1;
               if (grant_slot == slot_t'(PED)) begin
                  state_d = S_WALK;
                  tmr_val = WALK_LD;
               end else begin
                  state_d = S_GREEN;
                  tmr_val = GREEN_LD;
               end
            end
         end

         S_GREEN: begin
            if (ext_q) begin
               // Extended green ends when the car leaves or the ceiling is hit.
               if (tmr_zero || !cur_car) begin
                  state_d  = S_YELLOW;
                  ext_d    = 1'b0;
                  tmr_load = 1'b1;
                  tmr_val  = YELLOW_LD;
               end else begin
                  tmr_en = 1'b1;
               end
            end else if (!tmr_zero) begin
               tmr_en = 1'b1;
            end else if (CAN_EXTEND && cur_car) begin
               ext_d    = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = EXT_LD;
            end else begin
               state_d  = S_YELLOW;
               tmr_load = 1'b1;
               tmr_val  = YELLOW_LD;
            end
         end

         S_YELLOW: begin
            if (tmr_zero) begin
               state_d = S_ALLRED;
            end else begin
               tmr_en = 1'b1;
            end
         end

         S_WALK: begin
            if (tmr_zero) begin
               state_d = S_ALLRED;
            end else begin
               tmr_en = 1'b1;
            end
         end

         S_ALLRED: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Controller registers; reset drops any latched requests.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         last_q  <= slot_t'(PED);
         pend_q  <= '0;
         ext_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
         ext_q   <= ext_d;
      end
   end

   dwell_timer #(
      .CNT_W (CNT_W)
   ) u_dwell_timer (
      .clk_i      (clock_i),
      .rst_i      (reset_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .zero_o     (tmr_zero)
   );

   // Lamp decode: everything red and don't-walk unless a phase is active.
   always_comb begin
      bus.red       = '1;
      bus.yellow    = '0;
      bus.green     = '0;
      bus.walk      = 1'b0;
      bus.dont_walk = 1'b1;
      case (state_q)
         S_GREEN: begin
            bus.green = serve_oh;
            bus.red   = ~serve_oh;
         end
         S_YELLOW: begin
            bus.yellow = serve_oh;
            bus.red    = ~serve_oh;
         end
         S_WALK: begin
            bus.walk      = 1'b1;
            bus.dont_walk = 1'b0;
         end
         default: begin
         end
      endcase
   end

   assign bus.phase_idx = last_q[IDX_W-1:0];
   assign state_o       = state_q;

endmodule
